core_clint: RTL and testbench
=============================

# core_clint

Core-local interruptor (CLINT) for the single-hart NPC core. It holds the 64-bit `mtime` counter and the `mtimecmp` compare register, both memory-mapped to the MEM stage through a valid/ready request/response port. It drives `o_Clint_stop`, the registered "timer expired" level. The core control block ANDs that level with `mstatus.MIE` and `mie.MTIE` to raise the timer interrupt. This block is the source side of that interrupt path.

## Interface
- `BASE_ADDR`, default 64'h0000_0000_0200_0000: region base. Offsets are +0x0000 `msip` (only with `CLINT_MSIP_EN`), +0x4000 `mtimecmp`, +0xBFF8 `mtime`.
- `TICK_DIV`, default 1: `clk` cycles per `mtime` increment; legal range ≥1.
- `clk`  in  1  the only clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_Clint_req_valid`  in  1  MEM-stage access request.
- `o_Clint_req_ready`  out  1  block can accept a request this cycle.
- `i_Clint_addr`  in  64  byte address; bits [2:0] ignored.
- `i_Clint_wen`  in  1  1 = write, 0 = read.
- `i_Clint_wdata`  in  64  write data.
- `i_Clint_wstrb`  in  8  byte enables; bit k covers wdata[8k+7:8k].
- `o_Clint_resp_valid`  out  1  response available.
- `i_Clint_resp_ready`  in  1  MEM stage consumes the response.
- `o_Clint_rdata`  out  64  read data; 0 for writes and errors.
- `o_Clint_err`  out  1  response is for an unmapped offset.
- `o_Clint_stop`  out  1  registered (`mtime` ≥ `mtimecmp`), unsigned 64-bit compare.
- `o_Clint_msip`  out  1  software-interrupt pending; present only with `CLINT_MSIP_EN`.

## Operation
- Prescaler counts from 0 to `TICK_DIV`-1. A tick is issued when the prescaler equals `TICK_DIV`-1, and the prescaler then returns to 0. Each tick increments `mtime` by 1, modulo 2^64: all-ones wraps to 0, with no sticky flag.
- The access FSM has two states, IDLE and RESP.
  - IDLE: `o_Clint_req_ready`=1. When `i_Clint_req_valid`=1, the request is accepted and the FSM moves to RESP.
  - RESP: `o_Clint_req_ready`=0 and `o_Clint_resp_valid`=1. When `i_Clint_resp_ready`=1, the FSM returns to IDLE. No back-to-back acceptance: at most one access every 2 cycles.
- Decode uses (`i_Clint_addr` & ~7) − `BASE_ADDR` against the three offsets; any other value is unmapped.
- Write, applied at the acceptance edge:
  - Each enabled byte of the target register is updated.
  - A write to `mtime` overrides that cycle's tick increment.
  - A write to `mtime` with any strobe set clears the prescaler.
  - Unmapped writes change no state.
- Read: data is sampled at the acceptance edge and held stable throughout RESP, even while `mtime` keeps ticking.
- Unmapped access (read or write): response with `o_Clint_err`=1 and `o_Clint_rdata`=0.
- `o_Clint_stop` is a level, not a pulse. It stays high until software raises `mtimecmp` above `mtime` or lowers `mtime`.

## Timing
- Reset values:
  - `mtime`=0, prescaler=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF.
  - `msip`=0; FSM in IDLE.
  - `o_Clint_req_ready`=1; `o_Clint_resp_valid`=0, `o_Clint_rdata`=0, `o_Clint_err`=0, `o_Clint_stop`=0, `o_Clint_msip`=0.
- Request-to-response latency is 1 cycle: accepted at edge N, `o_Clint_resp_valid` is high after edge N.
- `o_Clint_stop` reflects register values after edge N at edge N+1. A tick or write at edge N therefore shows on the stop output one cycle later.
- `rst` asserted during RESP drops the response immediately (next edge), with no completion. A write accepted on the same edge that `rst` is high is discarded.
- `i_Clint_req_valid` is ignored while in RESP. The requester must hold its request until it sees ready.

## Configuration
- `CLINT_MSIP_EN` defined:
  - `msip` is a 1-bit register at +0x0000. Writes with `wstrb[0]`=1 load `wdata[0]`; reads return {63'b0, msip}.
  - `o_Clint_msip` equals the `msip` register, combinational.
- `CLINT_MSIP_EN` undefined:
  - No `msip` register and no `o_Clint_msip` port.
  - Offset +0x0000 is unmapped and returns `o_Clint_err`=1.

## Test plan
- Reset release with `TICK_DIV`=1, idle for 10 cycles → read `mtime` returns 10±1 exactly per acceptance edge; `o_Clint_stop`=0.
- Write `mtimecmp`=20 with `wstrb`=8'hFF; wait → `o_Clint_stop` rises exactly one cycle after `mtime` reaches 20 and stays high. Then write `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF → stop falls one cycle later.
- `TICK_DIV`=4 → `mtime` advances once per 4 cycles. A write of `mtime`=100 mid-count → next increment to 101 occurs 4 cycles after the write.
- Write `mtime`=64'hFFFF_FFFF_FFFF_FFFE with `mtimecmp`=0 → after 2 ticks `mtime`=0 (wraps); `o_Clint_stop` stays 1 throughout.
- Partial write of `mtimecmp`=64'h0, then `wdata`=64'h1122_3344_5566_7788 with `wstrb`=8'h0F → readback is 64'h0000_0000_5566_7788. Hold `i_Clint_resp_ready`=0 for 5 cycles → `o_Clint_rdata` is stable and `o_Clint_req_ready`=0 throughout.
- Read at `BASE_ADDR`+0x8 → `o_Clint_err`=1, `o_Clint_rdata`=0. Read at +0x0 → err=1 without `CLINT_MSIP_EN`. With the macro, write 1 then read → `o_Clint_rdata`=1 and `o_Clint_msip`=1.

Source files
------------

// File: rtl/core_clint.sv
// core_clint: core-local interruptor holding mtime / mtimecmp behind a
// single-outstanding valid/ready request/response port.
// Optional feature macro: CLINT_MSIP_EN adds the msip register at +0x0000
// and the o_Clint_msip output; without it that offset is unmapped.
module core_clint #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_Clint_req_valid,
   output logic        o_Clint_req_ready,
   input  logic [63:0] i_Clint_addr,
   input  logic        i_Clint_wen,
   input  logic [63:0] i_Clint_wdata,
   input  logic [7:0]  i_Clint_wstrb,
   output logic        o_Clint_resp_valid,
   input  logic        i_Clint_resp_ready,
   output logic [63:0] o_Clint_rdata,
   output logic        o_Clint_err,
   output logic        o_Clint_stop
`ifdef CLINT_MSIP_EN
   ,
   output logic        o_Clint_msip
`endif
);

   localparam logic [0:0]  ST_IDLE      = 1'b0;
   localparam logic [0:0]  ST_RESP      = 1'b1;
   localparam logic [63:0] OFF_MSIP     = 64'h0000;
   localparam logic [63:0] OFF_MTIMECMP = 64'h4000;
   localparam logic [63:0] OFF_MTIME    = 64'hBFF8;
   localparam logic [31:0] PRESC_MAX    = 32'(TICK_DIV - 1);

   logic [0:0]  state;
   logic [31:0] presc;
   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic [63:0] offset;
   logic [63:0] rd_mux;
   logic        accept;
   logic        tick;
   logic        hit_mtime;
   logic        hit_cmp;
   logic        hit_msip;
   logic        mapped;
   logic        wr_mtime;
   logic        wr_cmp;
`ifdef CLINT_MSIP_EN
   logic        msip;
`endif

   function automatic logic [63:0] merge(input logic [63:0] old,
                                         input logic [63:0] wdata,
                                         input logic [7:0]  strb);
      logic [63:0] res;
      res = old;
      for (int unsigned k = 0; k < 8; k++)
         if (strb[k]) res[8*k +: 8] = wdata[8*k +: 8];
      return res;
   endfunction

   // Address decode, acceptance and read-data selection
   always_comb begin
      offset    = (i_Clint_addr & ~64'h7) - BASE_ADDR;
      hit_mtime = (offset == OFF_MTIME);
      hit_cmp   = (offset == OFF_MTIMECMP);
`ifdef CLINT_MSIP_EN
      hit_msip  = (offset == OFF_MSIP);
`else
      hit_msip  = 1'b0;
`endif
      mapped    = hit_mtime | hit_cmp | hit_msip;
      accept    = (state == ST_IDLE) & i_Clint_req_valid;
      wr_mtime  = accept & i_Clint_wen & hit_mtime;
      wr_cmp    = accept & i_Clint_wen & hit_cmp;
      tick      = (presc == PRESC_MAX);
      rd_mux    = '0;
      if (hit_mtime)     rd_mux = mtime;
      else if (hit_cmp)  rd_mux = mtimecmp;
`ifdef CLINT_MSIP_EN
      else if (hit_msip) rd_mux = {63'b0, msip};
`endif
   end

   // Prescaler and mtime; a software write to mtime replaces that cycle's tick
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         mtime <= '0;
      end else if (wr_mtime) begin
         mtime <= merge(mtime, i_Clint_wdata, i_Clint_wstrb);
         if (|i_Clint_wstrb) presc <= '0;
         else                presc <= tick ? '0 : presc + 32'd1;
      end else begin
         presc <= tick ? '0 : presc + 32'd1;
         if (tick) mtime <= mtime + 64'd1;
      end
   end

   // mtimecmp byte-enabled write
   always_ff @(posedge clk) begin
      if (rst)         mtimecmp <= '1;
      else if (wr_cmp) mtimecmp <= merge(mtimecmp, i_Clint_wdata, i_Clint_wstrb);
   end

`ifdef CLINT_MSIP_EN
   // Software interrupt pending bit
   always_ff @(posedge clk) begin
      if (rst)                                                   msip <= 1'b0;
      else if (accept && i_Clint_wen && hit_msip && i_Clint_wstrb[0]) msip <= i_Clint_wdata[0];
   end

   assign o_Clint_msip = msip;
`endif

   // Registered timer-expired level
   always_ff @(posedge clk) begin
      if (rst) o_Clint_stop <= 1'b0;
      else     o_Clint_stop <= (mtime >= mtimecmp);
   end

   // Access FSM; response data is captured at acceptance and held during RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         o_Clint_rdata <= '0;
         o_Clint_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state         <= ST_RESP;
                  o_Clint_err   <= ~mapped;
                  o_Clint_rdata <= (i_Clint_wen | ~mapped) ? '0 : rd_mux;
               end
            end
            default: begin
               if (i_Clint_resp_ready) state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_Clint_req_ready  = (state == ST_IDLE);
   assign o_Clint_resp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_core_clint.sv
// tb_core_clint: directed, table-driven bench for core_clint. Two instances
// (TICK_DIV=1 and TICK_DIV=4) share clock, reset and the request bus.
module tb_core_clint;

   localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
   localparam logic [63:0] OFF_CMP  = 64'h4000;
   localparam logic [63:0] OFF_TIME = 64'hBFF8;
   localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [63:0] addr = '0;
   logic        wen = 1'b0;
   logic [63:0] wdata = '0;
   logic [7:0]  wstrb = '0;
   logic        resp_ready = 1'b1;

   logic        rdy1, rv1, err1, stop1;
   logic [63:0] rd1;
   logic        rdy4, rv4, err4, stop4;
   logic [63:0] rd4;
`ifdef CLINT_MSIP_EN
   logic        msip1, msip4;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   core_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
      .clk(clk), .rst(rst),
      .i_Clint_req_valid(req_valid), .o_Clint_req_ready(rdy1),
      .i_Clint_addr(addr), .i_Clint_wen(wen), .i_Clint_wdata(wdata), .i_Clint_wstrb(wstrb),
      .o_Clint_resp_valid(rv1), .i_Clint_resp_ready(resp_ready),
      .o_Clint_rdata(rd1), .o_Clint_err(err1), .o_Clint_stop(stop1)
`ifdef CLINT_MSIP_EN
      , .o_Clint_msip(msip1)
`endif
   );

   core_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
      .clk(clk), .rst(rst),
      .i_Clint_req_valid(req_valid), .o_Clint_req_ready(rdy4),
      .i_Clint_addr(addr), .i_Clint_wen(wen), .i_Clint_wdata(wdata), .i_Clint_wstrb(wstrb),
      .o_Clint_resp_valid(rv4), .i_Clint_resp_ready(resp_ready),
      .o_Clint_rdata(rd4), .o_Clint_err(err4), .o_Clint_stop(stop4)
`ifdef CLINT_MSIP_EN
      , .o_Clint_msip(msip4)
`endif
   );

   typedef struct {
      logic [63:0] off;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic [63:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [63:0] off, input logic w, input logic [63:0] wd,
                      input logic [7:0] ws, input logic [63:0] er, input logic ee);
      vec_t v;
      v.off = off; v.wen = w; v.wdata = wd; v.wstrb = ws; v.exp_rdata = er; v.exp_err = ee;
      tbl.push_back(v);
   endtask

   // Reset ends 1 ns after the last edge sampled with rst high
   task automatic do_reset();
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // One access: accepted on the next edge, response consumed on the edge after
   task automatic access(input logic [63:0] off, input logic w, input logic [63:0] wd,
                         input logic [7:0] ws, output logic [63:0] r1, output logic e1,
                         output logic [63:0] r4, output logic e4, output logic s1);
      chk("req_ready_idle", {63'b0, rdy1}, 64'd1);
      req_valid = 1'b1; addr = BASE + off; wen = w; wdata = wd; wstrb = ws; resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("resp_valid", {63'b0, rv1}, 64'd1);
      chk("req_ready_resp", {63'b0, rdy1}, 64'd0);
      r1 = rd1; e1 = err1; r4 = rd4; e4 = err4; s1 = stop1;
      @(posedge clk); #1;
      chk("resp_done", {63'b0, rv1}, 64'd0);
   endtask

   logic [63:0] r1, r4;
   logic        e1, e4, s1;

   initial begin
      // ---------------- reset state and free-running mtime ----------------
      do_reset();
      chk("rst_req_ready", {63'b0, rdy1}, 64'd1);
      chk("rst_resp_valid", {63'b0, rv1}, 64'd0);
      chk("rst_rdata", rd1, 64'd0);
      chk("rst_err", {63'b0, err1}, 64'd0);
      chk("rst_stop", {63'b0, stop1}, 64'd0);
`ifdef CLINT_MSIP_EN
      chk("rst_msip", {63'b0, msip1}, 64'd0);
`endif
      repeat (10) begin @(posedge clk); #1; end
      access(OFF_TIME, 1'b0, '0, '0, r1, e1, r4, e4, s1);
      chk("idle_mtime_div1", r1, 64'd10);
      chk("idle_mtime_div4", r4, 64'd2);
      chk("idle_err", {63'b0, e1}, 64'd0);
      chk("idle_stop", {63'b0, s1}, 64'd0);
      access(OFF_TIME, 1'b0, '0, '0, r1, e1, r4, e4, s1);
      chk("idle2_mtime_div1", r1, 64'd12);
      chk("idle2_mtime_div4", r4, 64'd3);

      // ---------------- stop rises one cycle after mtime reaches cmp ----------------
      do_reset();
      access(OFF_CMP, 1'b1, 64'd20, 8'hFF, r1, e1, r4, e4, s1);
      chk("cmp_wr_rdata", r1, 64'd0);
      chk("stop_e2", {63'b0, stop1}, 64'd0);
      for (int e = 3; e <= 25; e++) begin
         @(posedge clk); #1;
         chk($sformatf("stop_e%0d", e), {63'b0, stop1}, {63'b0, (e >= 21)});
      end
      access(OFF_CMP, 1'b1, ONES, 8'hFF, r1, e1, r4, e4, s1);
      chk("stop_still_high", {63'b0, s1}, 64'd1);
      chk("stop_fallen", {63'b0, stop1}, 64'd0);

      // ---------------- TICK_DIV=4: mtime write clears the prescaler ----------------
      do_reset();
      access(OFF_CMP, 1'b1, 64'd101, 8'hFF, r1, e1, r4, e4, s1);
      access(OFF_TIME, 1'b1, 64'd100, 8'hFF, r1, e1, r4, e4, s1);
      chk("div4_w1_stop", {63'b0, stop4}, 64'd0);
      for (int k = 2; k <= 6; k++) begin
         @(posedge clk); #1;
         chk($sformatf("div4_w%0d_stop", k), {63'b0, stop4}, {63'b0, (k >= 5)});
      end
      access(OFF_TIME, 1'b0, '0, '0, r1, e1, r4, e4, s1);
      chk("div4_mtime_101", r4, 64'd101);

      // ---------------- mtime wrap with mtimecmp=0 ----------------
      do_reset();
      access(OFF_CMP, 1'b1, 64'd0, 8'hFF, r1, e1, r4, e4, s1);
      chk("wrap_stop0", {63'b0, stop1}, 64'd1);
      access(OFF_TIME, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, r1, e1, r4, e4, s1);
      chk("wrap_stop1", {63'b0, s1}, 64'd1);
      chk("wrap_stop2", {63'b0, stop1}, 64'd1);
      @(posedge clk); #1;
      chk("wrap_stop3", {63'b0, stop1}, 64'd1);
      access(OFF_TIME, 1'b0, '0, '0, r1, e1, r4, e4, s1);
      chk("wrap_mtime", r1, 64'd0);
      chk("wrap_mtime_div4", r4, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("wrap_stop4", {63'b0, s1}, 64'd1);
      chk("wrap_stop5", {63'b0, stop1}, 64'd1);

      // ---------------- register access table ----------------
      do_reset();
      add(OFF_CMP,          1'b1, 64'h0,                   8'hFF, 64'h0,                   1'b0);
      add(OFF_CMP,          1'b1, 64'h1122_3344_5566_7788, 8'h0F, 64'h0,                   1'b0);
      add(OFF_CMP,          1'b0, 64'h0,                   8'h00, 64'h0000_0000_5566_7788, 1'b0);
      add(OFF_CMP + 64'h4,  1'b0, 64'h0,                   8'h00, 64'h0000_0000_5566_7788, 1'b0);
      add(OFF_CMP,          1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 64'h0,                   1'b0);
      add(OFF_CMP,          1'b0, 64'h0,                   8'h00, 64'hDEAD_BEEF_5566_7788, 1'b0);
      add(64'h8,            1'b1, ONES,                    8'hFF, 64'h0,                   1'b1);
      add(64'h8,            1'b0, 64'h0,                   8'h00, 64'h0,                   1'b1);
`ifdef CLINT_MSIP_EN
      add(64'h0,            1'b1, 64'h3,                   8'h01, 64'h0,                   1'b0);
      add(64'h0,            1'b0, 64'h0,                   8'h00, 64'h1,                   1'b0);
`else
      add(64'h0,            1'b1, 64'h1,                   8'h01, 64'h0,                   1'b1);
      add(64'h0,            1'b0, 64'h0,                   8'h00, 64'h0,                   1'b1);
`endif
      add(64'hBFF0,         1'b1, ONES,                    8'hFF, 64'h0,                   1'b1);
      add(64'h4008,         1'b0, 64'h0,                   8'h00, 64'h0,                   1'b1);
      add(64'hC000,         1'b0, 64'h0,                   8'h00, 64'h0,                   1'b1);
      add(ONES - 64'h7,     1'b0, 64'h0,                   8'h00, 64'h0,                   1'b1);
      add(OFF_CMP,          1'b1, 64'h0,                   8'h00, 64'h0,                   1'b0);
      add(OFF_CMP,          1'b0, 64'h0,                   8'h00, 64'hDEAD_BEEF_5566_7788, 1'b0);
      for (int i = 0; i < tbl.size(); i++) begin
         access(tbl[i].off, tbl[i].wen, tbl[i].wdata, tbl[i].wstrb, r1, e1, r4, e4, s1);
         chk($sformatf("tbl%0d_rdata", i), r1, tbl[i].exp_rdata);
         chk($sformatf("tbl%0d_err", i), {63'b0, e1}, {63'b0, tbl[i].exp_err});
         chk($sformatf("tbl%0d_rdata4", i), r4, tbl[i].exp_rdata);
      end
`ifdef CLINT_MSIP_EN
      chk("msip_out", {63'b0, msip1}, 64'd1);
`endif

      // ---------------- response held while resp_ready is low ----------------
      req_valid = 1'b1; addr = BASE + OFF_CMP; wen = 1'b0; wstrb = '0; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("hold%0d_rdata", c), rd1, 64'hDEAD_BEEF_5566_7788);
         chk($sformatf("hold%0d_ready", c), {63'b0, rdy1}, 64'd0);
         chk($sformatf("hold%0d_valid", c), {63'b0, rv1}, 64'd1);
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_valid", {63'b0, rv1}, 64'd0);
      chk("hold_release_ready", {63'b0, rdy1}, 64'd1);

      // ---------------- reset during RESP, write during reset ----------------
      req_valid = 1'b1; addr = BASE + OFF_CMP; wen = 1'b0; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstresp_valid_before", {63'b0, rv1}, 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rstresp_valid_after", {63'b0, rv1}, 64'd0);
      chk("rstresp_rdata", rd1, 64'd0);
      req_valid = 1'b1; addr = BASE + OFF_CMP; wen = 1'b1; wdata = 64'd5; wstrb = 8'hFF;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; rst = 1'b0;
      chk("rstwr_no_resp", {63'b0, rv1}, 64'd0);
      access(OFF_CMP, 1'b0, '0, '0, r1, e1, r4, e4, s1);
      chk("rstwr_discarded", r1, ONES);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
